// File: rtl/nv_ram_rws_512x64_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nv_ram_rws_512x64_fifo_ctrl_pkg
//
// Purpose : Shared sizing constants and small helpers for the 512x64
//           RAM-backed FIFO controller.
// Contents: depth, data width, RAM address width, occupancy-count width,
//           pointer width (address bits plus one wrap bit) and a helper that
//           extracts the RAM address from a wrap-extended pointer.
// -----------------------------------------------------------------------------
package nv_ram_rws_512x64_fifo_ctrl_pkg;

   localparam int FIFO_DEPTH = 512;
   localparam int DATA_W     = 64;
   localparam int ADDR_W     = 9;
   localparam int CNT_W      = 10;
   // One extra bit above the RAM address distinguishes laps around the RAM.
   localparam int PTR_W      = ADDR_W + 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   // Low bits of a wrap-extended pointer select the RAM word.
   function automatic logic [ADDR_W-1:0] ptr_addr(input logic [PTR_W-1:0] ptr);
      return ptr[ADDR_W-1:0];
   endfunction

endpackage : nv_ram_rws_512x64_fifo_ctrl_pkg

// File: rtl/nv_ram_rws_512x64_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// nv_ram_rws_512x64_fifo_ctrl
//
// Purpose : Valid/ready FIFO controller in front of an external 512x64
//           single-clock RAM with one write port and one registered read
//           port. One read-ahead word is held on rd_pd (straight from the RAM
//           output register); further words are fetched only when the held
//           word is being consumed or nothing is held.
//
// Ports   : nvdla_core_clk   - sole clock, rising edge
//           nvdla_core_rstn  - asynchronous assert, active-low reset
//           wr_pvld/wr_prdy/wr_pd [63:0] - write side handshake and payload
//           rd_pvld/rd_prdy/rd_pd [63:0] - read side handshake and payload
//           ram_we/ram_wa [8:0]/ram_di [63:0] - RAM write port
//           ram_re/ram_ra [8:0]               - RAM read-address port
//           ram_dout [63:0]  - RAM read data, valid the cycle after ram_re,
//                              held until the next ram_re
//           fifo_count [9:0] - registered occupancy, 0..512
// -----------------------------------------------------------------------------
module nv_ram_rws_512x64_fifo_ctrl
   import nv_ram_rws_512x64_fifo_ctrl_pkg::*;
(
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,

   input  logic              wr_pvld,
   output logic              wr_prdy,
   input  logic [DATA_W-1:0] wr_pd,

   output logic              rd_pvld,
   input  logic              rd_prdy,
   output logic [DATA_W-1:0] rd_pd,

   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_wa,
   output logic [DATA_W-1:0] ram_di,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_ra,
   input  logic [DATA_W-1:0] ram_dout,

   output logic [CNT_W-1:0]  fifo_count
);

   // State
   logic [PTR_W-1:0] wr_ptr_q,       wr_ptr_d;
   logic [PTR_W-1:0] rd_issue_ptr_q, rd_issue_ptr_d;
   logic [CNT_W-1:0] fifo_count_q,   fifo_count_d;
   logic             rd_pvld_q,      rd_pvld_d;

   // Combinational helpers
   logic             wr_accept;
   logic             rd_accept;
   logic             rd_issue;
   logic [CNT_W-1:0] unfetched;

   // -------------------------------------------------------------------------
   // Handshake and RAM control
   // -------------------------------------------------------------------------
   always_comb begin
      // Full is judged on the registered count only, so a read accept in the
      // same cycle does not open the write side until the following cycle.
      wr_prdy   = (fifo_count_q < FULL_CNT);
      wr_accept = wr_pvld & wr_prdy;
      rd_accept = rd_pvld_q & rd_prdy;

      // The word on rd_pd is still counted in fifo_count, so its RAM slot
      // cannot be reused until it is accepted. Entries not yet fetched are
      // the count minus that presented word.
      unfetched = fifo_count_q - {{(CNT_W-1){1'b0}}, rd_pvld_q};

      // Fetch when there is something left in the RAM and the output register
      // is free or being emptied this cycle. A word written this cycle is not
      // counted until the next edge, so it cannot be fetched in the same
      // cycle it is written.
      rd_issue  = (unfetched != '0) & (~rd_pvld_q | rd_prdy);
   end

   assign ram_we     = wr_accept;
   assign ram_wa     = ptr_addr(wr_ptr_q);
   assign ram_di     = wr_pd;
   assign ram_re     = rd_issue;
   assign ram_ra     = ptr_addr(rd_issue_ptr_q);

   assign rd_pvld    = rd_pvld_q;
   assign rd_pd      = ram_dout;
   assign fifo_count = fifo_count_q;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_issue_ptr_d = rd_issue_ptr_q;
      fifo_count_d   = fifo_count_q;
      rd_pvld_d      = rd_pvld_q;

      // Pointers are 10 bits and roll over 1023 -> 0 naturally.
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_issue) begin
         rd_issue_ptr_d = rd_issue_ptr_q + PTR_W'(1);
      end

      case ({wr_accept, rd_accept})
         2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
         2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
         default: fifo_count_d = fifo_count_q;
      endcase

      // A fetch always lands on rd_pd next cycle; otherwise an accepted word
      // leaves the output empty.
      if (rd_issue) begin
         rd_pvld_d = 1'b1;
      end else if (rd_accept) begin
         rd_pvld_d = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Registers. Reset only clears control state; RAM contents are left as-is
   // and become unreachable because both pointers restart at zero together.
   // -------------------------------------------------------------------------
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr_q       <= '0;
         rd_issue_ptr_q <= '0;
         fifo_count_q   <= '0;
         rd_pvld_q      <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_issue_ptr_q <= rd_issue_ptr_d;
         fifo_count_q   <= fifo_count_d;
         rd_pvld_q      <= rd_pvld_d;
      end
   end

endmodule : nv_ram_rws_512x64_fifo_ctrl

// File: tb/tb_nv_ram_rws_512x64_fifo_ctrl.sv
module tb_nv_ram_rws_512x64_fifo_ctrl;

   logic        clk;
   logic        rstn;
   logic        wr_pvld;
   logic        wr_prdy;
   logic [63:0] wr_pd;
   logic        rd_pvld;
   logic        rd_prdy;
   logic [63:0] rd_pd;
   logic        ram_we;
   logic [8:0]  ram_wa;
   logic [63:0] ram_di;
   logic        ram_re;
   logic [8:0]  ram_ra;
   logic [63:0] ram_dout;
   logic [9:0]  fifo_count;

   int errors = 0;
   int checks = 0;

   // Scoreboard: payloads pushed on write accept, popped on read accept.
   logic [63:0] sb_q[$];
   int          model_count = 0;

   nv_ram_rws_512x64_fifo_ctrl dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .wr_pvld         (wr_pvld),
      .wr_prdy         (wr_prdy),
      .wr_pd           (wr_pd),
      .rd_pvld         (rd_pvld),
      .rd_prdy         (rd_prdy),
      .rd_pd           (rd_pd),
      .ram_we          (ram_we),
      .ram_wa          (ram_wa),
      .ram_di          (ram_di),
      .ram_re          (ram_re),
      .ram_ra          (ram_ra),
      .ram_dout        (ram_dout),
      .fifo_count      (fifo_count)
   );

   // Behavioural 512x64 RAM: registered read, output held between reads.
   logic [63:0] mem [0:511];
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) ram_dout <= mem[ram_ra];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: reference occupancy and data ordering, sampled on falling edge.
   always @(negedge clk) begin
      if (!rstn) begin
         model_count = 0;
         sb_q.delete();
      end else begin
         chk("count_model", 64'(fifo_count), 64'(model_count));
         chk("wr_prdy_model", 64'(wr_prdy), 64'(model_count < 512));
         if (model_count == 0) begin
            chk("empty_rd_pvld", 64'(rd_pvld), 64'(0));
            chk("empty_ram_re", 64'(ram_re), 64'(0));
         end
         if (rd_pvld && rd_prdy) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got read %h expected no read", rd_pd);
            end else begin
               chk("sb_data", rd_pd, sb_q.pop_front());
            end
         end
         if (wr_pvld && wr_prdy) sb_q.push_back(wr_pd);
         model_count = model_count + int'(wr_pvld && wr_prdy) - int'(rd_pvld && rd_prdy);
      end
   end

   typedef struct {
      logic        wr_pvld;
      logic        rd_prdy;
      logic [63:0] wr_pd;
      logic        exp_wr_prdy;
      logic        exp_rd_pvld;
      logic        exp_ram_re;
      logic        exp_ram_we;
      logic [9:0]  exp_count;
   } vec_t;

   vec_t vecs[6];

   task automatic drain(input int budget);
      int n;
      n = 0;
      rd_prdy = 1'b1;
      wr_pvld = 1'b0;
      @(negedge clk);
      while (fifo_count != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 64'(fifo_count), 64'(0));
   endtask

   initial begin
      logic [63:0] held;
      int gaps;
      int n;

      vecs[0] = '{1'b1, 1'b0, 64'hAAAA_0000_0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0};
      vecs[1] = '{1'b1, 1'b0, 64'hBBBB_0000_0000_0002, 1'b1, 1'b0, 1'b1, 1'b1, 10'd1};
      vecs[2] = '{1'b0, 1'b0, 64'h0,                   1'b1, 1'b1, 1'b0, 1'b0, 10'd2};
      vecs[3] = '{1'b0, 1'b1, 64'h0,                   1'b1, 1'b1, 1'b1, 1'b0, 10'd2};
      vecs[4] = '{1'b0, 1'b1, 64'h0,                   1'b1, 1'b1, 1'b0, 1'b0, 10'd1};
      vecs[5] = '{1'b0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 1'b0, 10'd0};

      rstn    = 1'b0;
      wr_pvld = 1'b0;
      rd_prdy = 1'b0;
      wr_pd   = '0;
      repeat (3) @(posedge clk);
      #1;
      // Reset values while reset is held
      chk("rst_count", 64'(fifo_count), 64'(0));
      chk("rst_wr_prdy", 64'(wr_prdy), 64'(1));
      chk("rst_rd_pvld", 64'(rd_pvld), 64'(0));
      chk("rst_ram_re", 64'(ram_re), 64'(0));
      chk("rst_ram_we", 64'(ram_we), 64'(0));
      rstn = 1'b1;

      // Table-driven cycle vectors
      for (int i = 0; i < 6; i++) begin
         step();
         wr_pvld = vecs[i].wr_pvld;
         rd_prdy = vecs[i].rd_prdy;
         wr_pd   = vecs[i].wr_pd;
         @(negedge clk);
         $display("vec %0d: wr_pvld=%0b rd_prdy=%0b wr_prdy=%0b rd_pvld=%0b ram_re=%0b ram_we=%0b count=%0d",
                  i, wr_pvld, rd_prdy, wr_prdy, rd_pvld, ram_re, ram_we, fifo_count);
         chk($sformatf("vec%0d_wr_prdy", i), 64'(wr_prdy), 64'(vecs[i].exp_wr_prdy));
         chk($sformatf("vec%0d_rd_pvld", i), 64'(rd_pvld), 64'(vecs[i].exp_rd_pvld));
         chk($sformatf("vec%0d_ram_re", i), 64'(ram_re), 64'(vecs[i].exp_ram_re));
         chk($sformatf("vec%0d_ram_we", i), 64'(ram_we), 64'(vecs[i].exp_ram_we));
         chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].exp_count));
      end

      // Latency: write at cycle 0 -> ram_re at 1 -> rd_pvld at 2 -> empty at 3
      step();
      wr_pvld = 1'b1; wr_pd = 64'h0000_0000_0000_00A5; rd_prdy = 1'b1;
      @(negedge clk);
      chk("lat_c0_we", 64'(ram_we), 64'(1));
      chk("lat_c0_re", 64'(ram_re), 64'(0));
      step();
      wr_pvld = 1'b0;
      @(negedge clk);
      chk("lat_c1_re", 64'(ram_re), 64'(1));
      chk("lat_c1_ra", 64'(ram_ra), 64'(2));
      step();
      @(negedge clk);
      chk("lat_c2_pvld", 64'(rd_pvld), 64'(1));
      chk("lat_c2_pd", rd_pd, 64'h0000_0000_0000_00A5);
      step();
      @(negedge clk);
      chk("lat_c3_count", 64'(fifo_count), 64'(0));
      chk("lat_c3_pvld", 64'(rd_pvld), 64'(0));
      $display("latency sequence done");

      // Fill to 512 with the reader stalled
      rd_prdy = 1'b0;
      for (int i = 0; i < 512; i++) begin
         step();
         wr_pvld = 1'b1;
         wr_pd   = 64'(i);
      end
      step();
      wr_pd = 64'hDEAD_DEAD_DEAD_DEAD;
      @(negedge clk);
      chk("full_count", 64'(fifo_count), 64'(512));
      chk("full_wr_prdy", 64'(wr_prdy), 64'(0));
      chk("full_ram_we", 64'(ram_we), 64'(0));
      $display("fill done: count=%0d", fifo_count);

      // Stall: rd_pd must hold and no fetch happens
      step();
      wr_pvld = 1'b0;
      held = rd_pd;
      chk("stall_head", held, 64'(0));
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         chk("stall_pvld", 64'(rd_pvld), 64'(1));
         chk("stall_re", 64'(ram_re), 64'(0));
         chk("stall_pd", rd_pd, held);
      end

      // Full with simultaneous read accept: write still rejected this cycle
      step();
      rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 64'hBEEF;
      @(negedge clk);
      chk("fullrd_wr_prdy", 64'(wr_prdy), 64'(0));
      chk("fullrd_ram_we", 64'(ram_we), 64'(0));
      step();
      rd_prdy = 1'b0; wr_pvld = 1'b0;
      @(negedge clk);
      chk("fullrd_next_count", 64'(fifo_count), 64'(511));
      chk("fullrd_next_wr_prdy", 64'(wr_prdy), 64'(1));
      step();
      drain(700);
      $display("drain after full done");

      // Sustained streaming through pointer wrap
      step();
      rd_prdy = 1'b1;
      gaps = 0;
      for (int k = 0; k < 2000; k++) begin
         wr_pvld = 1'b1;
         wr_pd   = 64'h1000 + 64'(k);
         @(negedge clk);
         if (k >= 2 && !(rd_pvld && rd_prdy)) gaps++;
         if (!wr_prdy) gaps++;
         step();
      end
      chk("stream_gaps", 64'(gaps), 64'(0));
      wr_pvld = 1'b0;
      drain(20);
      $display("streaming done: 2000 transfers");

      // Asynchronous reset with 37 entries stored
      rd_prdy = 1'b0;
      for (int i = 0; i < 37; i++) begin
         step();
         wr_pvld = 1'b1;
         wr_pd   = 64'h5000 + 64'(i);
      end
      step();
      wr_pvld = 1'b0;
      @(negedge clk);
      chk("pre_rst_count", 64'(fifo_count), 64'(37));
      step();
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_count", 64'(fifo_count), 64'(0));
      chk("arst_wr_prdy", 64'(wr_prdy), 64'(1));
      chk("arst_rd_pvld", 64'(rd_pvld), 64'(0));
      chk("arst_ram_re", 64'(ram_re), 64'(0));
      chk("arst_ram_we", 64'(ram_we), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      step();
      wr_pvld = 1'b1; wr_pd = 64'h1234; rd_prdy = 1'b1;
      step();
      wr_pvld = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rd_pvld && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("post_rst_pvld", 64'(rd_pvld), 64'(1));
      chk("post_rst_pd", rd_pd, 64'h1234);
      $display("post-reset read: %h", rd_pd);
      step();
      repeat (3) @(negedge clk);
      chk("sb_empty_end", 64'(sb_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_nv_ram_rws_512x64_fifo_ctrl
